reg_rename_unit: RTL and testbench
==================================

// Module: reg_rename_unit
// PURPOSE
//  Rename stage between decode and the register file. Maps architectural
//  MIPS registers to physical registers using a map table, a circular
//  free list and per-physical-register busy bits. Renamed operands go to the
//  register file one cycle after acceptance. Writeback clears busy bits.
//  Commit returns the previous physical mapping to the free list.
// PARAMETERS
//  ARCH_REGS  32  architectural registers; the index width is 5
//  PHYS_REGS  64  physical registers; PW = $clog2(PHYS_REGS)
//  FL_DEPTH   PHYS_REGS-ARCH_REGS  free-list capacity
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous reset, active-high
//  i_valid          in   1   the decoded instruction is present
//  i_uses_rs/rt/rw  in   1   operand or destination is used
//  i_rs/rt/rw_addr  in   5   architectural register addresses
//  i_stall          in   1   downstream stall; hold the output register
//  o_ready          out  1   the instruction is accepted this cycle
//  o_valid          out  1   the renamed instruction is valid
//  o_uses_rs/rt/rw  out  1   registered copies of the uses flags
//  o_rs/rt_phys     out  PW  physical source registers
//  o_rw_phys        out  PW  newly allocated physical destination
//  o_old_rw_phys    out  PW  previous mapping of rw (used at commit)
//  o_rs/rt_busy     out  1   source value is not yet written back
//  i_wb_valid       in   1   writeback of a physical register
//  i_wb_phys        in   PW  physical register being written back
//  i_commit_valid   in   1   commit; free the old mapping
//  i_commit_phys    in   PW  physical register pushed to the free list
// BEHAVIOUR
//  Reset:
//   - map[i] = i for every architectural register i.
//   - The free list holds ARCH_REGS..PHYS_REGS-1 in ascending order. Head = 0, tail = 0, count = FL_DEPTH (full).
//   - Every busy bit is 0.
//   - o_valid is 0; all other outputs are 0.
//  Allocation:
//   - alloc = i_uses_rw && i_rw_addr != 0.
//   - Register 0 is never renamed: a destination of 0 forces o_uses_rw = 0 and o_rw_phys = 0.
//  Ready:
//   - o_ready = !i_stall && !(alloc && count == 0).
//   - o_ready is combinational.
//   - An entry pushed by commit in the same cycle does not raise o_ready.
//  Accept (i_valid && o_ready), 1-cycle latency:
//   - The output register loads the rs/rt/old-rw lookups from the map before this cycle's update.
//   - If alloc:
//     - o_rw_phys = fl[head]; head++ modulo FL_DEPTH.
//     - map[rw] <= o_rw_phys.
//     - busy[o_rw_phys] <= 1.
//   - A source equal to rw in the same instruction uses the old mapping.
//  Not accepted:
//   - If i_stall: all outputs hold.
//   - Otherwise o_valid <= 0.
//  Busy outputs:
//   - Each busy bit is sampled after the same-cycle writeback bypass: a source whose physical register equals i_wb_phys reads busy = 0.
//   - While the output is held, o_rs_busy and o_rt_busy keep updating: each drops to 0 when its register is written back.
//  Writeback: busy[i_wb_phys] <= 0.
//   - Writeback has priority over a same-cycle allocation only if the allocated register is different. An allocated register cannot be outstanding.
//  Commit:
//   - i_commit_phys == 0: the push is ignored.
//   - Otherwise: fl[tail] <= i_commit_phys; tail++ modulo FL_DEPTH.
//   - Count: push alone +1; pop alone -1; push and pop together unchanged.
//   - A push when count == FL_DEPTH is dropped and fires a simulation assertion.
//  Widths: head and tail are $clog2(FL_DEPTH) bits and wrap explicitly. count is $clog2(FL_DEPTH+1) bits.
//  Reset mid-operation restores the reset state on the next edge. In-flight output and busy state are discarded.
//  Branch-recovery flush is not supported by this block.
// TESTING
//  T1 After reset, rename rs=5, rt=6 with no rw -> next cycle o_rs_phys=5, o_rt_phys=6, both busy=0, o_valid=1.
//  T2 Rename rw=3 -> o_rw_phys=32, o_old_rw_phys=3. A later read of rs=3 gives phys 32 with busy=1.
//  T3 i_wb_phys=32 in the same cycle as the rs=3 lookup -> o_rs_busy=0; busy[32] is 0 afterwards.
//  T4 32 back-to-back renames of rw=1..31,1 -> allocates 32..63 and count reaches 0; the 33rd rename sees o_ready=0.
//     Then i_commit_phys=1 -> the next cycle o_ready=1 and the allocation is 1 (wrap-around).
//  T5 rw=0 -> o_uses_rw=0, the free-list count does not change and o_ready=1 even with an empty free list.
//  T6 Assert i_stall with o_valid=1 -> outputs hold for 3 cycles and o_ready=0. Assert rst mid-stream -> map is identity and count=32.

Source files
------------

// File: rtl/reg_rename_unit_if.sv
// Rename-stage port bundle: decode request, renamed output, writeback and commit.
// Decode handshake: an instruction moves when i_valid && o_ready on a clock edge; o_valid marks the registered result.
interface reg_rename_unit_if #(
    parameter int PW = 6,
    parameter int CW = 6
);
    logic          i_valid;
    logic          i_uses_rs;
    logic          i_uses_rt;
    logic          i_uses_rw;
    logic [4:0]    i_rs_addr;
    logic [4:0]    i_rt_addr;
    logic [4:0]    i_rw_addr;
    logic          i_stall;
    logic          o_ready;
    logic          o_valid;
    logic          o_uses_rs;
    logic          o_uses_rt;
    logic          o_uses_rw;
    logic [PW-1:0] o_rs_phys;
    logic [PW-1:0] o_rt_phys;
    logic [PW-1:0] o_rw_phys;
    logic [PW-1:0] o_old_rw_phys;
    logic          o_rs_busy;
    logic          o_rt_busy;
    logic          i_wb_valid;
    logic [PW-1:0] i_wb_phys;
    logic          i_commit_valid;
    logic [PW-1:0] i_commit_phys;
    logic [CW-1:0] dbg_fl_count;

    modport master (
        output i_valid, i_uses_rs, i_uses_rt, i_uses_rw,
        output i_rs_addr, i_rt_addr, i_rw_addr, i_stall,
        output i_wb_valid, i_wb_phys, i_commit_valid, i_commit_phys,
        input  o_ready, o_valid, o_uses_rs, o_uses_rt, o_uses_rw,
        input  o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys,
        input  o_rs_busy, o_rt_busy, dbg_fl_count
    );

    modport slave (
        input  i_valid, i_uses_rs, i_uses_rt, i_uses_rw,
        input  i_rs_addr, i_rt_addr, i_rw_addr, i_stall,
        input  i_wb_valid, i_wb_phys, i_commit_valid, i_commit_phys,
        output o_ready, o_valid, o_uses_rs, o_uses_rt, o_uses_rw,
        output o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys,
        output o_rs_busy, o_rt_busy, dbg_fl_count
    );
endinterface

// File: rtl/reg_rename_unit.sv
// Register rename stage: map table, circular free list and busy bits.
// Renamed operands are registered one cycle after acceptance.
module reg_rename_unit #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
) (
    input logic              clk,
    input logic              rst,
    reg_rename_unit_if.slave bus
);
    localparam int PW       = $clog2(PHYS_REGS);
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int HW       = $clog2(FL_DEPTH);
    localparam int CW       = $clog2(FL_DEPTH + 1);

    logic [PW-1:0]        map_q [ARCH_REGS];
    logic [PW-1:0]        map_d [ARCH_REGS];
    logic [PW-1:0]        fl_q [FL_DEPTH];
    logic [PW-1:0]        fl_d [FL_DEPTH];
    logic [PHYS_REGS-1:0] busy_q, busy_d;
    logic [HW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;

    logic          o_valid_q, o_valid_d;
    logic          o_uses_rs_q, o_uses_rs_d, o_uses_rt_q, o_uses_rt_d, o_uses_rw_q, o_uses_rw_d;
    logic [PW-1:0] o_rs_phys_q, o_rs_phys_d, o_rt_phys_q, o_rt_phys_d;
    logic [PW-1:0] o_rw_phys_q, o_rw_phys_d, o_old_rw_phys_q, o_old_rw_phys_d;
    logic          o_rs_busy_q, o_rs_busy_d, o_rt_busy_q, o_rt_busy_d;

    logic          alloc, fl_empty, fl_full, ready, accept, pop, push_req, push;
    logic [PW-1:0] new_phys, rs_map, rt_map, rw_map;
    logic          rs_busy_now, rt_busy_now;

    always_comb begin
        alloc       = bus.i_uses_rw && (bus.i_rw_addr != 5'd0);
        fl_empty    = (count_q == '0);
        fl_full     = (count_q == CW'(FL_DEPTH));
        ready       = !bus.i_stall && !(alloc && fl_empty);
        accept      = bus.i_valid && ready;
        pop         = accept && alloc;
        push_req    = bus.i_commit_valid && (bus.i_commit_phys != '0);
        push        = push_req && !fl_full;
        new_phys    = fl_q[head_q];
        rs_map      = map_q[bus.i_rs_addr];
        rt_map      = map_q[bus.i_rt_addr];
        rw_map      = map_q[bus.i_rw_addr];
        // Same-cycle writeback bypass on the busy lookup
        rs_busy_now = busy_q[rs_map] && !(bus.i_wb_valid && bus.i_wb_phys == rs_map);
        rt_busy_now = busy_q[rt_map] && !(bus.i_wb_valid && bus.i_wb_phys == rt_map);
    end

    always_comb begin
        map_d  = map_q;
        fl_d   = fl_q;
        busy_d = busy_q;
        head_d = head_q;
        tail_d = tail_q;
        count_d = count_q;
        if (pop) begin
            map_d[bus.i_rw_addr] = new_phys;
            head_d = (head_q == HW'(FL_DEPTH - 1)) ? '0 : head_q + 1'b1;
        end
        if (push) begin
            fl_d[tail_q] = bus.i_commit_phys;
            tail_d = (tail_q == HW'(FL_DEPTH - 1)) ? '0 : tail_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Allocation is applied last so it wins if writeback names the same register
        if (bus.i_wb_valid) busy_d[bus.i_wb_phys] = 1'b0;
        if (pop)            busy_d[new_phys] = 1'b1;
    end

    always_comb begin
        o_valid_d       = o_valid_q;
        o_uses_rs_d     = o_uses_rs_q;
        o_uses_rt_d     = o_uses_rt_q;
        o_uses_rw_d     = o_uses_rw_q;
        o_rs_phys_d     = o_rs_phys_q;
        o_rt_phys_d     = o_rt_phys_q;
        o_rw_phys_d     = o_rw_phys_q;
        o_old_rw_phys_d = o_old_rw_phys_q;
        o_rs_busy_d     = o_rs_busy_q && !(bus.i_wb_valid && bus.i_wb_phys == o_rs_phys_q);
        o_rt_busy_d     = o_rt_busy_q && !(bus.i_wb_valid && bus.i_wb_phys == o_rt_phys_q);
        if (accept) begin
            o_valid_d       = 1'b1;
            o_uses_rs_d     = bus.i_uses_rs;
            o_uses_rt_d     = bus.i_uses_rt;
            o_uses_rw_d     = alloc;
            o_rs_phys_d     = rs_map;
            o_rt_phys_d     = rt_map;
            o_rw_phys_d     = alloc ? new_phys : '0;
            o_old_rw_phys_d = alloc ? rw_map : '0;
            o_rs_busy_d     = rs_busy_now;
            o_rt_busy_d     = rt_busy_now;
        end else if (!bus.i_stall) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
            for (int i = 0; i < FL_DEPTH; i++)  fl_q[i]  <= PW'(ARCH_REGS + i);
            busy_q          <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= CW'(FL_DEPTH);
            o_valid_q       <= 1'b0;
            o_uses_rs_q     <= 1'b0;
            o_uses_rt_q     <= 1'b0;
            o_uses_rw_q     <= 1'b0;
            o_rs_phys_q     <= '0;
            o_rt_phys_q     <= '0;
            o_rw_phys_q     <= '0;
            o_old_rw_phys_q <= '0;
            o_rs_busy_q     <= 1'b0;
            o_rt_busy_q     <= 1'b0;
        end else begin
            map_q           <= map_d;
            fl_q            <= fl_d;
            busy_q          <= busy_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            o_valid_q       <= o_valid_d;
            o_uses_rs_q     <= o_uses_rs_d;
            o_uses_rt_q     <= o_uses_rt_d;
            o_uses_rw_q     <= o_uses_rw_d;
            o_rs_phys_q     <= o_rs_phys_d;
            o_rt_phys_q     <= o_rt_phys_d;
            o_rw_phys_q     <= o_rw_phys_d;
            o_old_rw_phys_q <= o_old_rw_phys_d;
            o_rs_busy_q     <= o_rs_busy_d;
            o_rt_busy_q     <= o_rt_busy_d;
        end
    end

    // A commit into a full free list means a register was freed twice
    a_no_fl_overflow: assert property (@(posedge clk) disable iff (rst) !(push_req && fl_full));

    assign bus.o_ready       = ready;
    assign bus.o_valid       = o_valid_q;
    assign bus.o_uses_rs     = o_uses_rs_q;
    assign bus.o_uses_rt     = o_uses_rt_q;
    assign bus.o_uses_rw     = o_uses_rw_q;
    assign bus.o_rs_phys     = o_rs_phys_q;
    assign bus.o_rt_phys     = o_rt_phys_q;
    assign bus.o_rw_phys     = o_rw_phys_q;
    assign bus.o_old_rw_phys = o_old_rw_phys_q;
    assign bus.o_rs_busy     = o_rs_busy_q;
    assign bus.o_rt_busy     = o_rt_busy_q;
    assign bus.dbg_fl_count  = count_q;
endmodule

// File: tb/tb_reg_rename_unit.sv
// Directed bench for reg_rename_unit: reset, lookup, allocation, bypass, wrap, stall and reset recovery.
module tb_reg_rename_unit;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    reg_rename_unit_if #(.PW(6), .CW(6)) bus ();

    reg_rename_unit #(.ARCH_REGS(32), .PHYS_REGS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_valid        = 1'b0;
        bus.i_uses_rs      = 1'b0;
        bus.i_uses_rt      = 1'b0;
        bus.i_uses_rw      = 1'b0;
        bus.i_rs_addr      = 5'd0;
        bus.i_rt_addr      = 5'd0;
        bus.i_rw_addr      = 5'd0;
        bus.i_stall        = 1'b0;
        bus.i_wb_valid     = 1'b0;
        bus.i_wb_phys      = 6'd0;
        bus.i_commit_valid = 1'b0;
        bus.i_commit_phys  = 6'd0;
    endtask

    task automatic drive_rename(input logic urs, input logic [4:0] rs, input logic urt,
                                input logic [4:0] rt, input logic urw, input logic [4:0] rw);
        bus.i_valid   = 1'b1;
        bus.i_uses_rs = urs;
        bus.i_rs_addr = rs;
        bus.i_uses_rt = urt;
        bus.i_rt_addr = rt;
        bus.i_uses_rw = urw;
        bus.i_rw_addr = rw;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0d exp=0", bus.o_valid); end
        n_tests++; if (bus.o_rs_phys !== 6'd0) begin n_fail++; $display("FAIL reset_rs_phys got=%0d exp=0", bus.o_rs_phys); end
        n_tests++; if (bus.o_rw_phys !== 6'd0) begin n_fail++; $display("FAIL reset_rw_phys got=%0d exp=0", bus.o_rw_phys); end
        n_tests++; if (bus.dbg_fl_count !== 6'd32) begin n_fail++; $display("FAIL reset_count got=%0d exp=32", bus.dbg_fl_count); end
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0d exp=1", bus.o_ready); end
    endtask

    task automatic test_lookup();
        drive_rename(1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 5'd0);
        step();
        drive_idle();
        n_tests++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid got=%0d exp=1", bus.o_valid); end
        n_tests++; if (bus.o_rs_phys !== 6'd5) begin n_fail++; $display("FAIL t1_rs_phys got=%0d exp=5", bus.o_rs_phys); end
        n_tests++; if (bus.o_rt_phys !== 6'd6) begin n_fail++; $display("FAIL t1_rt_phys got=%0d exp=6", bus.o_rt_phys); end
        n_tests++; if ({bus.o_rs_busy, bus.o_rt_busy} !== 2'b00) begin n_fail++; $display("FAIL t1_busy got=%b exp=00", {bus.o_rs_busy, bus.o_rt_busy}); end
        n_tests++; if (bus.o_uses_rw !== 1'b0) begin n_fail++; $display("FAIL t1_uses_rw got=%0d exp=0", bus.o_uses_rw); end
        step();
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_drop got=%0d exp=0", bus.o_valid); end
    endtask

    task automatic test_alloc();
        drive_rename(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        step();
        n_tests++; if (bus.o_rw_phys !== 6'd32) begin n_fail++; $display("FAIL t2_rw_phys got=%0d exp=32", bus.o_rw_phys); end
        n_tests++; if (bus.o_old_rw_phys !== 6'd3) begin n_fail++; $display("FAIL t2_old_rw got=%0d exp=3", bus.o_old_rw_phys); end
        n_tests++; if (bus.o_uses_rw !== 1'b1) begin n_fail++; $display("FAIL t2_uses_rw got=%0d exp=1", bus.o_uses_rw); end
        n_tests++; if (bus.dbg_fl_count !== 6'd31) begin n_fail++; $display("FAIL t2_count got=%0d exp=31", bus.dbg_fl_count); end
        drive_rename(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        n_tests++; if (bus.o_rs_phys !== 6'd32) begin n_fail++; $display("FAIL t2_rs_phys got=%0d exp=32", bus.o_rs_phys); end
        n_tests++; if (bus.o_rs_busy !== 1'b1) begin n_fail++; $display("FAIL t2_rs_busy got=%0d exp=1", bus.o_rs_busy); end
    endtask

    task automatic test_wb_bypass();
        drive_rename(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        bus.i_wb_valid = 1'b1;
        bus.i_wb_phys  = 6'd32;
        step();
        bus.i_wb_valid = 1'b0;
        n_tests++; if (bus.o_rs_busy !== 1'b0) begin n_fail++; $display("FAIL t3_bypass got=%0d exp=0", bus.o_rs_busy); end
        step();
        n_tests++; if (bus.o_rs_phys !== 6'd32) begin n_fail++; $display("FAIL t3_rs_phys got=%0d exp=32", bus.o_rs_phys); end
        n_tests++; if (bus.o_rs_busy !== 1'b0) begin n_fail++; $display("FAIL t3_busy_cleared got=%0d exp=0", bus.o_rs_busy); end
        drive_idle();
    endtask

    task automatic test_same_reg();
        // map[3]=32 (written back), next free entry is 33
        drive_rename(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd7);
        step();
        n_tests++; if (bus.o_rs_phys !== 6'd7) begin n_fail++; $display("FAIL same_rs_old got=%0d exp=7", bus.o_rs_phys); end
        n_tests++; if (bus.o_rt_phys !== 6'd32) begin n_fail++; $display("FAIL same_rt got=%0d exp=32", bus.o_rt_phys); end
        n_tests++; if (bus.o_rw_phys !== 6'd33) begin n_fail++; $display("FAIL same_rw got=%0d exp=33", bus.o_rw_phys); end
        n_tests++; if (bus.o_old_rw_phys !== 6'd7) begin n_fail++; $display("FAIL same_old_rw got=%0d exp=7", bus.o_old_rw_phys); end
        drive_rename(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        n_tests++; if (bus.o_rs_phys !== 6'd33) begin n_fail++; $display("FAIL same_rs_new got=%0d exp=33", bus.o_rs_phys); end
        n_tests++; if (bus.o_rs_busy !== 1'b1) begin n_fail++; $display("FAIL same_rs_busy got=%0d exp=1", bus.o_rs_busy); end
        drive_idle();
    endtask

    task automatic test_back_to_back_wrap();
        logic [4:0] rw;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            rw = (k < 31) ? 5'(k + 1) : 5'd1;
            drive_rename(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, rw);
            #1;
            n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL t4_ready[%0d] got=%0d exp=1", k, bus.o_ready); end
            step();
            n_tests++; if (bus.o_rw_phys !== 6'(32 + k)) begin n_fail++; $display("FAIL t4_alloc[%0d] got=%0d exp=%0d", k, bus.o_rw_phys, 32 + k); end
        end
        n_tests++; if (bus.o_old_rw_phys !== 6'd32) begin n_fail++; $display("FAIL t4_old_rw1 got=%0d exp=32", bus.o_old_rw_phys); end
        n_tests++; if (bus.dbg_fl_count !== 6'd0) begin n_fail++; $display("FAIL t4_count_empty got=%0d exp=0", bus.dbg_fl_count); end
        drive_rename(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2);
        #1;
        n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL t4_ready_empty got=%0d exp=0", bus.o_ready); end
        bus.i_commit_valid = 1'b1;
        bus.i_commit_phys  = 6'd1;
        #1;
        n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL t4_ready_same_push got=%0d exp=0", bus.o_ready); end
        step();
        bus.i_commit_valid = 1'b0;
        #1;
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL t4_valid_blocked got=%0d exp=0", bus.o_valid); end
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL t4_ready_after_push got=%0d exp=1", bus.o_ready); end
        step();
        n_tests++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL t4_valid_wrap got=%0d exp=1", bus.o_valid); end
        n_tests++; if (bus.o_rw_phys !== 6'd1) begin n_fail++; $display("FAIL t4_alloc_wrap got=%0d exp=1", bus.o_rw_phys); end
        n_tests++; if (bus.o_old_rw_phys !== 6'd33) begin n_fail++; $display("FAIL t4_old_rw2 got=%0d exp=33", bus.o_old_rw_phys); end
        drive_idle();
    endtask

    task automatic test_zero_dest();
        // Free list is empty; map[2]=1 and busy[1]=1
        drive_rename(1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 5'd0);
        #1;
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL t5_ready got=%0d exp=1", bus.o_ready); end
        step();
        n_tests++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL t5_valid got=%0d exp=1", bus.o_valid); end
        n_tests++; if (bus.o_uses_rw !== 1'b0) begin n_fail++; $display("FAIL t5_uses_rw got=%0d exp=0", bus.o_uses_rw); end
        n_tests++; if (bus.o_rw_phys !== 6'd0) begin n_fail++; $display("FAIL t5_rw_phys got=%0d exp=0", bus.o_rw_phys); end
        n_tests++; if (bus.o_rs_phys !== 6'd1) begin n_fail++; $display("FAIL t5_rs_phys got=%0d exp=1", bus.o_rs_phys); end
        n_tests++; if (bus.o_rs_busy !== 1'b1) begin n_fail++; $display("FAIL t5_rs_busy got=%0d exp=1", bus.o_rs_busy); end
        n_tests++; if (bus.dbg_fl_count !== 6'd0) begin n_fail++; $display("FAIL t5_count got=%0d exp=0", bus.dbg_fl_count); end
    endtask

    task automatic test_stall_and_reset();
        drive_rename(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        bus.i_stall = 1'b1;
        #1;
        n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL t6_ready_stall got=%0d exp=0", bus.o_ready); end
        for (int c = 0; c < 3; c++) begin
            bus.i_wb_valid = (c == 1);
            bus.i_wb_phys  = (c == 1) ? 6'd1 : 6'd0;
            step();
            n_tests++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL t6_hold_valid[%0d] got=%0d exp=1", c, bus.o_valid); end
            n_tests++; if (bus.o_rs_phys !== 6'd1) begin n_fail++; $display("FAIL t6_hold_rs[%0d] got=%0d exp=1", c, bus.o_rs_phys); end
            n_tests++; if (bus.o_rs_busy !== (c == 0)) begin n_fail++; $display("FAIL t6_hold_busy[%0d] got=%0d exp=%0d", c, bus.o_rs_busy, c == 0); end
        end
        drive_idle();
        drive_rename(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        rst = 1'b1;
        drive_rename(1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 5'd9);
        step();
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL t6_rst_valid got=%0d exp=0", bus.o_valid); end
        n_tests++; if (bus.dbg_fl_count !== 6'd32) begin n_fail++; $display("FAIL t6_rst_count got=%0d exp=32", bus.dbg_fl_count); end
        rst = 1'b0;
        drive_rename(1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 5'd5);
        step();
        n_tests++; if (bus.o_rs_phys !== 6'd2) begin n_fail++; $display("FAIL t6_map_rs got=%0d exp=2", bus.o_rs_phys); end
        n_tests++; if (bus.o_rt_phys !== 6'd1) begin n_fail++; $display("FAIL t6_map_rt got=%0d exp=1", bus.o_rt_phys); end
        n_tests++; if ({bus.o_rs_busy, bus.o_rt_busy} !== 2'b00) begin n_fail++; $display("FAIL t6_busy got=%b exp=00", {bus.o_rs_busy, bus.o_rt_busy}); end
        n_tests++; if (bus.o_rw_phys !== 6'd32) begin n_fail++; $display("FAIL t6_head got=%0d exp=32", bus.o_rw_phys); end
        drive_idle();
        step();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_lookup();
        test_alloc();
        test_wb_bypass();
        test_same_reg();
        test_back_to_back_wrap();
        test_zero_dest();
        test_stall_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
